// File: rtl/alu_op_sequencer.sv
// Four-state sequencer driving an 8-bit ALU: fetch operands, execute, write back or branch.
// Optional `ALU_SEQ_PERF_EN adds the perf_ops completed-instruction counter port.
module alu_op_sequencer #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 2,
  parameter int OP_W       = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OP_W-1:0]       instr_op,
  input  logic [REG_ADDR_W-1:0] instr_rs,
  input  logic [REG_ADDR_W-1:0] instr_rt,
  input  logic [REG_ADDR_W-1:0] instr_rd,
  output logic [REG_ADDR_W-1:0] rf_raddr1,
  output logic [REG_ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0]     rf_rdata1,
  input  logic [DATA_W-1:0]     rf_rdata2,
  output logic [DATA_W-1:0]     alu_data1,
  output logic [DATA_W-1:0]     alu_data2,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  done,
  output logic                  branch_taken,
  output logic                  err
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]           perf_ops
`endif
);

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_EQ  = OP_W'(6);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WB
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_rst_done;
  logic [OP_W-1:0]         r_op;
  logic [REG_ADDR_W-1:0]   r_rs;
  logic [REG_ADDR_W-1:0]   r_rt;
  logic [REG_ADDR_W-1:0]   r_rd;
  logic [DATA_W-1:0]       r_data1;
  logic [DATA_W-1:0]       r_data2;
  logic [DATA_W-1:0]       r_result;
  logic                    r_zero;
  logic                    w_accept;

  // Ready is held low for the cycle following a reset edge, even though the state is IDLE.
  assign instr_ready = (r_state == S_IDLE) && r_rst_done;
  assign w_accept    = instr_valid && instr_ready;
  assign alu_data1   = r_data1;
  assign alu_data2   = r_data2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rst_done <= 1'b0;
      r_op       <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_data1    <= '0;
      r_data2    <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rst_done <= 1'b1;
      if (w_accept) begin
        r_op <= instr_op;
        r_rs <= instr_rs;
        r_rt <= instr_rt;
        r_rd <= instr_rd;
      end
      if (r_state == S_FETCH) begin
        r_data1 <= rf_rdata1;
        r_data2 <= rf_rdata2;
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_result;
        r_zero   <= alu_zero;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    rf_raddr1    = '0;
    rf_raddr2    = '0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    done         = 1'b0;
    branch_taken = 1'b0;
    err          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_FETCH;
      end
      S_FETCH: begin
        rf_raddr1 = r_rs;
        rf_raddr2 = r_rt;
        w_next    = S_EXEC;
      end
      S_EXEC: begin
        w_next = S_WB;
      end
      S_WB: begin
        done   = 1'b1;
        w_next = S_IDLE;
        if (r_op == OP_ADD) begin
          rf_we    = 1'b1;
          rf_waddr = r_rd;
          rf_wdata = r_result;
        end else if (r_op == OP_EQ) begin
          branch_taken = r_zero;
        end else if (r_op != OP_NOP) begin
          err = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] r_perf_ops;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf_ops <= '0;
    end else if (r_state == S_WB) begin
      r_perf_ops <= r_perf_ops + 16'd1;
    end
  end

  assign perf_ops = r_perf_ops;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with behavioural register file / ALU and a result scoreboard.
module tb_alu_op_sequencer;

  logic       clk;
  logic       reset_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rs;
  logic [1:0] instr_rt;
  logic [1:0] instr_rd;
  logic [1:0] rf_raddr1;
  logic [1:0] rf_raddr2;
  logic [7:0] rf_rdata1;
  logic [7:0] rf_rdata2;
  logic [7:0] alu_data1;
  logic [7:0] alu_data2;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       done;
  logic       branch_taken;
  logic       err;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_ops;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       br;
    logic       er;
  } exp_t;
  exp_t sb[$];

  alu_op_sequencer #(.DATA_W(8), .REG_ADDR_W(2), .OP_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done(done), .branch_taken(branch_taken), .err(err)
`ifdef ALU_SEQ_PERF_EN
    , .perf_ops(perf_ops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model with a bench-side preload port; ALU model adds and compares.
  logic [7:0] rf [4];
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (ld_en) rf[ld_addr] <= ld_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  assign rf_rdata1  = rf[rf_raddr1];
  assign rf_rdata2  = rf[rf_raddr2];
  assign alu_result = alu_data1 + alu_data2;
  assign alu_zero   = (alu_data1 == alu_data2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_rf_we", rf_we, e.we);
        if (e.we) begin
          chk("wb_waddr", rf_waddr, e.waddr);
          chk("wb_wdata", rf_wdata, e.wdata);
        end
        chk("wb_branch", branch_taken, e.br);
        chk("wb_err", err, e.er);
      end
    end else begin
      chk("idle_we", rf_we, 1'b0);
      chk("idle_br_err", {branch_taken, err}, 2'b00);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Returns after the accepting edge, 1ns into the FETCH cycle.
  task automatic issue(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rt,
                       input logic [1:0] rd, input bit push, input logic we,
                       input logic [7:0] wdata, input logic br, input logic er,
                       output int waited);
    exp_t e;
    instr_valid = 1'b1;
    instr_op = op; instr_rs = rs; instr_rt = rt; instr_rd = rd;
    if (push) begin
      e.we = we; e.waddr = rd; e.wdata = wdata; e.br = br; e.er = er;
      sb.push_back(e);
    end
    waited = 0;
    while (instr_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) chk("ready_timeout", 32'd1, 32'd0);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int w;
    reset_n = 1'b0; instr_valid = 1'b1;
    instr_op = 3'b001; instr_rs = 2'd1; instr_rt = 2'd2; instr_rd = 2'd3;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset held two clocks with valid offered
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", instr_ready, 1'b0);
      chk("rst_raddr", {rf_raddr1, rf_raddr2}, 4'h0);
      chk("rst_alu_data", {alu_data1, alu_data2}, 16'h0000);
      chk("rst_wb", {rf_we, rf_waddr, rf_wdata, done, branch_taken, err}, 14'h0);
    end
    reset_n = 1'b1;
    tick();
    chk("ready_after_release", instr_ready, 1'b1);
    chk("nothing_accepted", rf_raddr1, 2'd0);
    instr_valid = 1'b0;

    // ADD 5 + 10 -> R3, cycle-exact timing
    load(2'd1, 8'h05);
    load(2'd2, 8'h0A);
    issue(3'b001, 2'd1, 2'd2, 2'd3, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, w);
    chk("fetch_raddr1", rf_raddr1, 2'd1);
    chk("fetch_raddr2", rf_raddr2, 2'd2);
    chk("fetch_busy", instr_ready, 1'b0);
    tick();
    chk("exec_data1", alu_data1, 8'h05);
    chk("exec_data2", alu_data2, 8'h0A);
    chk("exec_raddr", {rf_raddr1, rf_raddr2}, 4'h0);
    tick();
    chk("wb_done_n3", {done, rf_we}, 2'b11);
    tick();
    chk("idle_hold_data", {alu_data1, alu_data2}, 16'h050A);
    chk("idle_ready", instr_ready, 1'b1);
    chk("rf3_written", rf[3], 8'h0F);

    // Wrapping ADD, then a held instruction accepted exactly at N+4
    load(2'd1, 8'hF0);
    load(2'd2, 8'h20);
    issue(3'b001, 2'd1, 2'd2, 2'd0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, w);
    issue(3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, w);
    chk("held_accept_wait", w, 3);

    // EQ: equal operands, different operands, rs==rt
    load(2'd1, 8'h33);
    load(2'd2, 8'h33);
    issue(3'b110, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, w);
    issue(3'b110, 2'd1, 2'd0, 2'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, w);
    issue(3'b110, 2'd2, 2'd2, 2'd3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, w);

    // Unsupported opcodes
    issue(3'b011, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, w);
    issue(3'b111, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, w);
    drain();

    // Reset during EXEC abandons the ADD
    issue(3'b001, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, w);
    tick();
    reset_n = 1'b0;
    tick();
    chk("midrst_outputs", {done, rf_we, instr_ready}, 3'b000);
    chk("midrst_alu_data", {alu_data1, alu_data2}, 16'h0000);
    reset_n = 1'b1;
    tick();
    chk("midrst_ready", instr_ready, 1'b1);
    tick();
    chk("midrst_rf3_kept", rf[3], 8'h0F);

`ifdef ALU_SEQ_PERF_EN
    chk("perf_after_rst", perf_ops, 16'h0000);
    for (int k = 0; k < 3; k++)
      issue(3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, w);
    drain();
    chk("perf_three", perf_ops, 16'h0003);
    force dut.r_perf_ops = 16'hFFFF;
    #1;
    release dut.r_perf_ops;
    issue(3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, w);
    drain();
    chk("perf_wrap", perf_ops, 16'h0000);
`endif

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
